// File: rtl/unidad_riesgos.sv
// Hazard/stall controller for the 5-stage MIPS pipeline: load-use stall, branch flush, memory freeze and timeout trap.
// Control outputs are zero-latency Mealy; estado/error_espera/ciclos_parada are registered. A memory freeze holds for as long as memory is not ready.
module unidad_riesgos #(
   parameter int MAX_ESPERA = 16,
   parameter int ANCHO_CNT  = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [4:0]           rs_ID,
   input  logic [4:0]           rt_ID,
   input  logic                 usa_rt_ID,
   input  logic                 mem_leer_EX,
   input  logic [4:0]           rt_EX,
   input  logic                 branch_tomado_MEM,
   input  logic                 mem_acceso_MEM,
   input  logic                 mem_listo,
   output logic                 pc_escribir,
   output logic                 if_id_escribir,
   output logic                 if_id_limpiar,
   output logic                 id_ex_burbuja,
   output logic                 ex_mem_limpiar,
   output logic                 congelar,
   output logic [1:0]           estado,
   output logic                 error_espera,
   output logic [ANCHO_CNT-1:0] ciclos_parada
);

   localparam int W_ESP = $clog2(MAX_ESPERA) + 1;

   localparam logic [1:0] ST_RUN   = 2'b00;
   localparam logic [1:0] ST_WAIT  = 2'b01;
   localparam logic [1:0] ST_ERROR = 2'b10;

   logic [1:0]           estado_q, estado_d;
   logic [W_ESP-1:0]     espera_cnt_q, espera_cnt_d;
   logic                 error_q, error_d;
   logic [ANCHO_CNT-1:0] ciclos_q, ciclos_d;

   logic lu;
   logic mw;

   always_comb begin
      lu = mem_leer_EX && (rt_EX != 5'd0) &&
           ((rt_EX == rs_ID) || (usa_rt_ID && (rt_EX == rt_ID)));
      mw = mem_acceso_MEM && !mem_listo;
   end

   // WAIT with mw=1 collapses onto the RUN mw rule; WAIT with mw=0 is plain RUN.
   always_comb begin
      pc_escribir    = 1'b1;
      if_id_escribir = 1'b1;
      if_id_limpiar  = 1'b0;
      id_ex_burbuja  = 1'b0;
      ex_mem_limpiar = 1'b0;
      congelar       = 1'b0;
      if (estado_q == ST_ERROR) begin
         congelar       = 1'b1;
         pc_escribir    = 1'b0;
         if_id_escribir = 1'b0;
      end else if (mw) begin
         congelar       = 1'b1;
         pc_escribir    = 1'b0;
         if_id_escribir = 1'b0;
      end else if (branch_tomado_MEM) begin
         if_id_limpiar  = 1'b1;
         id_ex_burbuja  = 1'b1;
         ex_mem_limpiar = 1'b1;
      end else if (lu) begin
         pc_escribir    = 1'b0;
         if_id_escribir = 1'b0;
         id_ex_burbuja  = 1'b1;
      end
   end

   always_comb begin
      estado_d     = estado_q;
      espera_cnt_d = espera_cnt_q;
      error_d      = error_q;
      case (estado_q)
         ST_RUN: begin
            if (mw) begin
               estado_d     = ST_WAIT;
               espera_cnt_d = W_ESP'(1);
            end
         end
         ST_WAIT: begin
            if (!mw) begin
               estado_d     = ST_RUN;
               espera_cnt_d = '0;
            end else if (espera_cnt_q == W_ESP'(MAX_ESPERA - 1)) begin
               estado_d = ST_ERROR;
               error_d  = 1'b1;
            end else begin
               espera_cnt_d = espera_cnt_q + W_ESP'(1);
            end
         end
         ST_ERROR: begin
            estado_d = ST_ERROR;
         end
         default: begin
            estado_d     = ST_RUN;
            espera_cnt_d = '0;
         end
      endcase
   end

   always_comb begin
      ciclos_d = ciclos_q;
      if (!pc_escribir && (ciclos_q != {ANCHO_CNT{1'b1}})) begin
         ciclos_d = ciclos_q + ANCHO_CNT'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         estado_q     <= ST_RUN;
         espera_cnt_q <= '0;
         error_q      <= 1'b0;
         ciclos_q     <= '0;
      end else begin
         estado_q     <= estado_d;
         espera_cnt_q <= espera_cnt_d;
         error_q      <= error_d;
         ciclos_q     <= ciclos_d;
      end
   end

   assign estado        = estado_q;
   assign error_espera  = error_q;
   assign ciclos_parada = ciclos_q;

endmodule

// File: tb/tb_unidad_riesgos.sv
// Directed bench for unidad_riesgos with MAX_ESPERA=4, ANCHO_CNT=4.
module tb_unidad_riesgos;

   logic       clk;
   logic       reset;
   logic [4:0] rs_ID, rt_ID, rt_EX;
   logic       usa_rt_ID, mem_leer_EX, branch_tomado_MEM, mem_acceso_MEM, mem_listo;
   logic       pc_escribir, if_id_escribir, if_id_limpiar, id_ex_burbuja, ex_mem_limpiar, congelar;
   logic [1:0] estado;
   logic       error_espera;
   logic [3:0] ciclos_parada;
   logic [5:0] ctl;

   int tests_run = 0;
   int tests_failed = 0;

   unidad_riesgos #(.MAX_ESPERA(4), .ANCHO_CNT(4)) dut (
      .clk(clk), .reset(reset),
      .rs_ID(rs_ID), .rt_ID(rt_ID), .usa_rt_ID(usa_rt_ID),
      .mem_leer_EX(mem_leer_EX), .rt_EX(rt_EX),
      .branch_tomado_MEM(branch_tomado_MEM),
      .mem_acceso_MEM(mem_acceso_MEM), .mem_listo(mem_listo),
      .pc_escribir(pc_escribir), .if_id_escribir(if_id_escribir),
      .if_id_limpiar(if_id_limpiar), .id_ex_burbuja(id_ex_burbuja),
      .ex_mem_limpiar(ex_mem_limpiar), .congelar(congelar),
      .estado(estado), .error_espera(error_espera), .ciclos_parada(ciclos_parada)
   );

   // {pc, if_id_wr, if_id_clr, bubble, ex_mem_clr, freeze}
   assign ctl = {pc_escribir, if_id_escribir, if_id_limpiar, id_ex_burbuja, ex_mem_limpiar, congelar};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle();
      rs_ID = 5'd0; rt_ID = 5'd0; rt_EX = 5'd0;
      usa_rt_ID = 1'b0; mem_leer_EX = 1'b0; branch_tomado_MEM = 1'b0;
      mem_acceso_MEM = 1'b0; mem_listo = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle();
      #1;
      tests_run++;
      if (estado !== 2'b00) begin tests_failed++; $display("FAIL reset_estado got=%b exp=00", estado); end
      tests_run++;
      if (error_espera !== 1'b0 || ciclos_parada !== 4'd0) begin
         tests_failed++; $display("FAIL reset_regs got err=%b cnt=%0d exp err=0 cnt=0", error_espera, ciclos_parada);
      end
      tests_run++;
      if (ctl !== 6'b110000) begin tests_failed++; $display("FAIL reset_ctl got=%b exp=110000", ctl); end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_load_use();
      do_reset();
      mem_leer_EX = 1'b1; rt_EX = 5'd5; rs_ID = 5'd5;
      #1;
      tests_run++;
      if (ctl !== 6'b000100) begin tests_failed++; $display("FAIL lu_stall got=%b exp=000100", ctl); end
      @(posedge clk); #1;
      tests_run++;
      if (ciclos_parada !== 4'd1) begin tests_failed++; $display("FAIL lu_count got=%0d exp=1", ciclos_parada); end
      @(negedge clk);
      rt_EX = 5'd0; rs_ID = 5'd0;
      #1;
      tests_run++;
      if (ctl !== 6'b110000) begin tests_failed++; $display("FAIL lu_r0 got=%b exp=110000", ctl); end
      @(negedge clk);
      rt_EX = 5'd5; rs_ID = 5'd3; rt_ID = 5'd5; usa_rt_ID = 1'b0;
      #1;
      tests_run++;
      if (ctl !== 6'b110000) begin tests_failed++; $display("FAIL lu_rt_unused got=%b exp=110000", ctl); end
      @(negedge clk);
      usa_rt_ID = 1'b1;
      #1;
      tests_run++;
      if (ctl !== 6'b000100) begin tests_failed++; $display("FAIL lu_rt_used got=%b exp=000100", ctl); end
      @(posedge clk); #1;
      tests_run++;
      if (ciclos_parada !== 4'd2) begin tests_failed++; $display("FAIL lu_count2 got=%0d exp=2", ciclos_parada); end
   endtask

   task automatic test_branch_lu();
      do_reset();
      mem_leer_EX = 1'b1; rt_EX = 5'd7; rs_ID = 5'd7; branch_tomado_MEM = 1'b1;
      #1;
      tests_run++;
      if (ctl !== 6'b111110) begin tests_failed++; $display("FAIL br_lu got=%b exp=111110", ctl); end
      @(posedge clk); #1;
      tests_run++;
      if (ciclos_parada !== 4'd0) begin tests_failed++; $display("FAIL br_count got=%0d exp=0", ciclos_parada); end
   endtask

   task automatic test_mem_wait();
      logic [1:0] exp_est [3];
      exp_est[0] = 2'b00; exp_est[1] = 2'b01; exp_est[2] = 2'b01;
      do_reset();
      mem_acceso_MEM = 1'b1; mem_listo = 1'b0; branch_tomado_MEM = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         tests_run++;
         if (ctl !== 6'b000001 || estado !== exp_est[i]) begin
            tests_failed++; $display("FAIL mw_cycle%0d got ctl=%b est=%b exp ctl=000001 est=%b", i, ctl, estado, exp_est[i]);
         end
         @(negedge clk);
      end
      mem_listo = 1'b1;
      #1;
      tests_run++;
      if (ctl !== 6'b111110 || estado !== 2'b01) begin
         tests_failed++; $display("FAIL mw_release got ctl=%b est=%b exp ctl=111110 est=01", ctl, estado);
      end
      @(posedge clk); #1;
      tests_run++;
      if (estado !== 2'b00 || ciclos_parada !== 4'd3) begin
         tests_failed++; $display("FAIL mw_after got est=%b cnt=%0d exp est=00 cnt=3", estado, ciclos_parada);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      mem_acceso_MEM = 1'b1; mem_listo = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         @(posedge clk); #1;
         tests_run++;
         if (estado !== ((i < 4) ? 2'b01 : 2'b10) || error_espera !== (i == 4)) begin
            tests_failed++; $display("FAIL to_edge%0d got est=%b err=%b", i, estado, error_espera);
         end
      end
      @(negedge clk);
      idle();
      branch_tomado_MEM = 1'b1;
      #1;
      tests_run++;
      if (ctl !== 6'b000001 || estado !== 2'b10 || error_espera !== 1'b1) begin
         tests_failed++; $display("FAIL to_sticky got ctl=%b est=%b err=%b exp ctl=000001 est=10 err=1", ctl, estado, error_espera);
      end
      @(posedge clk); #1;
      tests_run++;
      if (ciclos_parada !== 4'd5 || estado !== 2'b10) begin
         tests_failed++; $display("FAIL to_count got cnt=%0d est=%b exp cnt=5 est=10", ciclos_parada, estado);
      end
      @(negedge clk);
      reset = 1'b1;
      #1;
      tests_run++;
      if (estado !== 2'b00 || error_espera !== 1'b0) begin
         tests_failed++; $display("FAIL to_reset got est=%b err=%b exp est=00 err=0", estado, error_espera);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset_in_wait();
      do_reset();
      mem_acceso_MEM = 1'b1; mem_listo = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      tests_run++;
      if (estado !== 2'b00 || error_espera !== 1'b0 || ciclos_parada !== 4'd0 || congelar !== 1'b1) begin
         tests_failed++; $display("FAIL rw_async got est=%b err=%b cnt=%0d frz=%b exp 00 0 0 1", estado, error_espera, ciclos_parada, congelar);
      end
      idle();
      #1;
      tests_run++;
      if (ctl !== 6'b110000) begin tests_failed++; $display("FAIL rw_idle got=%b exp=110000", ctl); end
      mem_acceso_MEM = 1'b1;
      @(posedge clk); #1;
      tests_run++;
      if (ciclos_parada !== 4'd0 || estado !== 2'b00) begin
         tests_failed++; $display("FAIL rw_held got cnt=%0d est=%b exp cnt=0 est=00", ciclos_parada, estado);
      end
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      tests_run++;
      if (estado !== 2'b01 || error_espera !== 1'b0) begin
         tests_failed++; $display("FAIL rw_cnt_cleared got est=%b err=%b exp est=01 err=0", estado, error_espera);
      end
      @(negedge clk);
      idle();
   endtask

   task automatic test_saturation();
      do_reset();
      mem_leer_EX = 1'b1; rt_EX = 5'd9; rs_ID = 5'd9;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         tests_run++;
         if (ciclos_parada !== ((i > 15) ? 4'd15 : 4'(i))) begin
            tests_failed++; $display("FAIL sat_%0d got=%0d exp=%0d", i, ciclos_parada, (i > 15) ? 15 : i);
         end
      end
      @(negedge clk);
      idle();
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_branch_lu();
      test_mem_wait();
      test_timeout();
      test_reset_in_wait();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/unidad_riesgos.md
# unidad_riesgos

Hazard and stall controller for the five-stage MIPS pipeline. It generates the write-enable, flush and freeze signals for the PC, IF/ID, ID/EX and EX/MEM registers. It detects load-use hazards, flushes the pipeline on taken branches, freezes the pipeline while data memory is not ready, and traps memory-wait timeouts. It also keeps a saturating stall-cycle counter for performance analysis.

## Interface
Parameters:
- MAX_ESPERA, default 16: consecutive memory-wait cycles before a timeout trap; must be ≥ 2.
- ANCHO_CNT, default 16: width of the stall-cycle counter.

Ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- rs_ID  in  5  rs field of the instruction in ID.
- rt_ID  in  5  rt field of the instruction in ID.
- usa_rt_ID  in  1  1 when the ID instruction reads rt as a source (R-type, beq, sw).
- mem_leer_EX  in  1  the instruction in EX is a load.
- rt_EX  in  5  destination register of the instruction in EX.
- branch_tomado_MEM  in  1  a branch in MEM resolved taken.
- mem_acceso_MEM  in  1  the instruction in MEM accesses data memory.
- mem_listo  in  1  data memory completes the access this cycle.
- pc_escribir  out  1  PC load enable.
- if_id_escribir  out  1  IF/ID load enable.
- if_id_limpiar  out  1  IF/ID loads zeros (nop).
- id_ex_burbuja  out  1  ID/EX loads zero control fields.
- ex_mem_limpiar  out  1  EX/MEM loads zero control fields.
- congelar  out  1  ID/EX, EX/MEM and MEM/WB hold their contents.
- estado  out  2  FSM state: 00 RUN, 01 WAIT, 10 ERROR.
- error_espera  out  1  sticky memory-timeout flag.
- ciclos_parada  out  ANCHO_CNT  count of cycles with pc_escribir=0.

## Operation
Derived terms:
- lu (load-use hazard) = mem_leer_EX & (rt_EX≠0) & ((rt_EX==rs_ID) | (usa_rt_ID & rt_EX==rt_ID)).
- mw (memory wait) = mem_acceso_MEM & ~mem_listo.

Default outputs: pc_escribir=1, if_id_escribir=1, all other 1-bit outputs 0.

Output rules in RUN, and in WAIT when mw=0. Rules are evaluated in priority order, first match wins:
1. mw: congelar=1, pc_escribir=0, if_id_escribir=0. No flush is issued.
2. branch_tomado_MEM: if_id_limpiar=1, id_ex_burbuja=1, ex_mem_limpiar=1, pc_escribir=1 (PC takes the branch target).
3. lu: pc_escribir=0, if_id_escribir=0, id_ex_burbuja=1.
4. Otherwise, default outputs.

Output rules in WAIT when mw=1: congelar=1, pc_escribir=0, if_id_escribir=0.

Output rules in ERROR: congelar=1, pc_escribir=0, if_id_escribir=0, error_espera=1. Inputs are ignored.

Transitions, taken at the clock edge:
- RUN, mw=1 → WAIT, with espera_cnt←1. Otherwise stay in RUN.
- WAIT, mw=0 → RUN.
- WAIT, mw=1, espera_cnt==MAX_ESPERA-1 → ERROR.
- WAIT, mw=1, any other espera_cnt → stay in WAIT, with espera_cnt←espera_cnt+1.
- ERROR → ERROR. Only reset leaves this state.

Counters:
- espera_cnt is internal and ⌈log2(MAX_ESPERA)⌉+1 bits wide.
- ciclos_parada increments at every edge where pc_escribir=0, in any state. It saturates at all-ones and never wraps.

## Timing
- All outputs except estado, error_espera and ciclos_parada are combinational (Mealy) functions of the current state and the inputs. They take effect in the same cycle the condition is seen, with zero latency.
- A load-use stall lasts exactly 1 cycle: the bubble clears mem_leer_EX on the next edge.
- A branch flush lasts 1 cycle.
- A memory freeze lasts for as long as mw=1, up to MAX_ESPERA cycles. The edge that ends the MAX_ESPERA-th consecutive mw cycle enters ERROR.
- On the cycle mem_listo rises, the FSM is still in WAIT but the RUN rules apply. A branch or load-use detected in that cycle is therefore handled immediately.
- Simultaneous events:
  - mw with branch or lu: mw wins; the branch and lu are re-evaluated after release.
  - Branch with lu: the flush wins and no stall is taken.
- Reset, asynchronous and at any time, including mid-WAIT or in ERROR:
  - estado=RUN, espera_cnt=0, ciclos_parada=0, error_espera=0.
  - While reset is held, the combinational outputs follow the RUN rules.
  - ciclos_parada does not count while reset is high.

## Test plan
- Reset during WAIT (espera_cnt=3) → estado=00, error_espera=0, ciclos_parada=0 immediately, without waiting for a clk edge. With idle inputs, pc_escribir=1 and if_id_escribir=1.
- Load-use stall:
  - Stimulus: mem_leer_EX=1, rt_EX=5, rs_ID=5 for one cycle.
  - Required: pc_escribir=0, if_id_escribir=0, id_ex_burbuja=1 in that cycle; ciclos_parada 0→1.
  - Repeat with rt_EX=0, and with rt_ID=5, usa_rt_ID=0 (rs_ID≠5) → no stall.
- Branch and lu together: branch_tomado_MEM=1 with the lu condition true → if_id_limpiar=id_ex_burbuja=ex_mem_limpiar=1, pc_escribir=1; ciclos_parada unchanged.
- Memory wait:
  - Stimulus: mem_acceso_MEM=1, mem_listo=0 for 3 cycles, then mem_listo=1.
  - Required: congelar=1 for exactly 3 cycles; estado RUN→WAIT→WAIT→RUN; ciclos_parada +3.
- Timeout with MAX_ESPERA=4:
  - Stimulus: mw held continuously.
  - Required: estado=10 and error_espera=1 after the 4th edge. Both hold with mw removed until reset; ciclos_parada keeps incrementing in ERROR.
- Counter saturation with ANCHO_CNT=4: 20 consecutive stall cycles → ciclos_parada stops at 15.
